des_key_sched_ctrl: RTL and testbench
=====================================

# des_key_sched_ctrl

Sequencer for the DES key schedule. It captures a 64-bit key, applies PC-1, and steps the 28-bit C/D halves through the 16-round rotation schedule. Each round it presents the PC-2-selected 48-bit round subkey to the round datapath over a valid/ready handshake. Encrypt order is K1..K16 and decrypt order is K16..K1. It sits between the key register/host interface and the Feistel round engine, and is the only driver of round subkeys.

## Interface
- KEY_PC1, default 1: 1 = key_in is a 64-bit key passed through PC-1 (parity bits dropped). 0 = key_in[55:0] is taken directly as C0D0 (C0 = key_in[55:28]).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new schedule; sampled only in IDLE
- decrypt  in  1  sampled with start; 0 = K1..K16, 1 = K16..K1
- key_in  in  64  key; bit 63 = FIPS bit 1 (MSB-first numbering throughout)
- subkey  out  48  PC-2(C,D) of the current CD register; bit 47 = PC-2 output bit 1
- subkey_valid  out  1  subkey and round_idx are valid
- subkey_ready  in  1  consumer accepts the subkey
- round_idx  out  4  index of the presented subkey minus 1 (K1 = 0, K16 = 15)
- busy  out  1  high in ROUND
- done  out  1  one-cycle pulse after the 16th accepted subkey

## Operation
- States: IDLE, ROUND. The step counter step[3:0] counts accepted subkeys, 0..15.
- Rotation schedule S[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D rotate independently, each 28 bits.
- IDLE with start=1: load CD from PC-1(key_in), or from key_in[55:0] when KEY_PC1=0. Latch decrypt. Set step=0 and enter ROUND. The initial rotation is applied in the same edge:
  - encrypt: rotate left by S[0]
  - decrypt: no rotation (C16D16 = C0D0)
- In ROUND, subkey_valid=1. subkey is combinational PC-2 of the CD register.
- round_idx = step when encrypting, 15−step when decrypting.
- Handshake (subkey_valid & subkey_ready at an edge):
  - If step<15: step increments by 1 and CD rotates for the next subkey.
    - encrypt: rotate left by S[step+1]
    - decrypt: rotate right by S[15−step]
  - If step=15: go to IDLE, assert done for the next cycle, and leave CD unchanged.
- subkey_ready low while valid: CD, step, subkey and round_idx hold stable. There is no timeout.
- start in ROUND is ignored. decrypt and key_in changes in ROUND are ignored.
- start in the cycle done is high is accepted, since the state is IDLE.
- Cumulative rotation after 16 encrypt rounds is 28, so C16D16 = C0D0. Decrypt reaches C1D1 at step 15.

## Timing
- Reset (async, any time including mid-schedule) returns to IDLE with:
  - subkey_valid=0, busy=0, done=0, step=0, round_idx=0
  - CD=0, so subkey=0
- The first subkey is valid 1 cycle after the start edge.
- Zero-wait consumer (ready held high): one subkey per cycle. 16 cycles from first valid to last acceptance.
- done is high exactly 1 cycle, in the cycle after the final handshake. busy falls in that same cycle.
- Minimum start-to-start period is 17 cycles.
- Every output is a register or a pure function of registers. There is no combinational path from subkey_ready or start to any output.

## Test plan
- Encrypt, key 133457799BBCDFF1, ready=1:
  - CD after start edge equals F0CCAAF/556678F rotated left by 1.
  - K1=1B02EFFC7072 and K2=79AED9DBC9E5.
  - K16=CB3D8B0E17F5 at round_idx=15.
  - done pulses once, 17 cycles after start.
- Decrypt, same key:
  - First subkey CB3D8B0E17F5 with round_idx=15.
  - Last subkey 1B02EFFC7072 with round_idx=0.
  - The sequence is the exact reverse of the encrypt run.
- Backpressure:
  - Hold ready low for 5 cycles on K3. subkey=K3 and round_idx=2 stay stable.
  - Random ready pattern: all 16 subkeys delivered once each, in order.
- start pulsed mid-schedule with a different key: ignored, and the sequence still matches the original key.
- Assert rst at step 7, then release: all outputs at reset values. A fresh start produces a correct full K1..K16.
- KEY_PC1=0 with key_in[55:0]=F0CCAAF556678F: K1=1B02EFFC7072. Back-to-back start on the done cycle: the second schedule begins with no gap.

Source files
------------

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: loads C0D0 (optionally through PC-1), rotates C/D each round and
// presents PC-2 subkeys over valid/ready; encrypt order K1..K16, decrypt order K16..K1.
module des_key_sched_ctrl #(
  parameter bit KEY_PC1 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_t;

  // Tables hold LSB-based bit positions (64 - FIPS position for PC-1, 56 - FIPS position for PC-2).
  localparam int PC1_IDX [56] = '{
     7, 15, 23, 31, 39, 47, 55, 63,  6, 14, 22, 30, 38, 46,
    54, 62,  5, 13, 21, 29, 37, 45, 53, 61,  4, 12, 20, 28,
     1,  9, 17, 25, 33, 41, 49, 57,  2, 10, 18, 26, 34, 42,
    50, 58,  3, 11, 19, 27, 35, 43, 51, 59, 36, 44, 52, 60};

  localparam int PC2_IDX [48] = '{
    42, 39, 45, 32, 55, 51, 53, 28, 41, 50, 35, 46,
    33, 37, 44, 52, 30, 48, 40, 49, 29, 36, 43, 54,
    15,  4, 25, 19,  9,  1, 26, 16,  5, 11, 23,  8,
    12,  7, 17,  0, 22,  3, 10, 14,  6, 20, 27, 24};

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [55:0] cd_q, cd_d;
  logic [55:0] key_pc1;
  logic [55:0] cd_load;
  logic        shift2;
  logic        unused_key;

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) rotate by one; all others by two.
  function automatic logic shift_two(input logic [3:0] j);
    return !(j == 4'd0 || j == 4'd1 || j == 4'd8 || j == 4'd15);
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic two, input logic left);
    logic [27:0] r;
    if (left) begin
      r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    end else begin
      r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    end
    return r;
  endfunction

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign key_pc1[55-i] = key_in[PC1_IDX[i]];
  end

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[47-i] = cd_q[PC2_IDX[i]];
  end

  assign cd_load    = KEY_PC1 ? key_pc1 : key_in[55:0];
  assign unused_key = ^key_in;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dec_d   = dec_q;
    cd_d    = cd_q;
    done_d  = 1'b0;
    shift2  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ROUND;
          step_d  = 4'd0;
          dec_d   = decrypt;
          // Decrypt starts from C16D16, which equals C0D0 since the schedule totals 28.
          cd_d    = decrypt ? cd_load
                            : {rot28(cd_load[55:28], 1'b0, 1'b1), rot28(cd_load[27:0], 1'b0, 1'b1)};
        end
      end
      ROUND: begin
        if (subkey_ready) begin
          if (step_q == 4'd15) begin
            state_d = IDLE;
            step_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            shift2 = dec_q ? shift_two(4'd15 - step_q) : shift_two(step_q + 4'd1);
            cd_d   = {rot28(cd_q[55:28], shift2, !dec_q), rot28(cd_q[27:0], shift2, !dec_q)};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
      cd_q    <= 56'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
      cd_q    <= cd_d;
    end
  end

  assign subkey_valid = (state_q == ROUND);
  assign busy         = (state_q == ROUND);
  assign done         = done_q;
  assign round_idx    = dec_q ? (4'd15 - step_q) : step_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Bench for des_key_sched_ctrl: FIPS-level key-schedule model checked every cycle on two
// instances (PC-1 load and raw C0D0 load) plus directed literal checks.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic        subkey_ready;
  logic [63:0] key_in;
  logic [47:0] subkey, subkey0;
  logic        subkey_valid, subkey_valid0;
  logic [3:0]  round_idx, round_idx0;
  logic        busy, busy0, done, done0;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY_RAW = 64'h00F0CCAAF556678F;

  always #5 clk = ~clk;

  des_key_sched_ctrl #(.KEY_PC1(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .subkey(subkey), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .round_idx(round_idx), .busy(busy), .done(done));

  des_key_sched_ctrl #(.KEY_PC1(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .subkey(subkey0), .subkey_valid(subkey_valid0), .subkey_ready(subkey_ready),
    .round_idx(round_idx0), .busy(busy0), .done(done0));

  // FIPS 46-3 tables, 1-based positions counted from the MSB.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] model_cd0(input logic [63:0] k, input bit pc1);
    logic [55:0] cd;
    cd = k[55:0];
    if (pc1) begin
      for (int i = 1; i <= 56; i++) cd[56-i] = k[64-PC1_T[i-1]];
    end
    return cd;
  endfunction

  // Subkey for round r (0-based) straight from the cumulative rotation of C0D0.
  function automatic logic [47:0] model_key(input logic [63:0] k, input bit pc1, input int r);
    logic [55:0] cd, cc, dd, cdr;
    logic [47:0] o;
    int tot;
    cd  = model_cd0(k, pc1);
    tot = 0;
    for (int i = 0; i <= r; i++) tot += SHIFTS[i];
    tot = tot % 28;
    cc  = {cd[55:28], cd[55:28]};
    dd  = {cd[27:0], cd[27:0]};
    cdr = {cc[55-tot -: 28], dd[55-tot -: 28]};
    for (int i = 1; i <= 48; i++) o[48-i] = cdr[56-PC2_T[i-1]];
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: which round is on offer, and what the idle subkey holds.
  bit          m_active = 1'b0;
  int          m_n = 0;
  bit          m_dec = 1'b0;
  bit          m_done = 1'b0;
  bit          m_idx_known = 1'b1;
  logic [63:0] m_key = 64'd0;
  logic [47:0] m_last1 = 48'd0;
  logic [47:0] m_last0 = 48'd0;
  logic [47:0] hs_q [$];
  logic [47:0] enc_seq [16];

  function automatic int m_round();
    return m_dec ? 15 - m_n : m_n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_n = 0; m_dec = 1'b0; m_done = 1'b0; m_idx_known = 1'b1;
      m_last1 = 48'd0; m_last0 = 48'd0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (subkey_ready) begin
          hs_q.push_back(subkey);
          m_last1 = model_key(m_key, 1'b1, m_round());
          m_last0 = model_key(m_key, 1'b0, m_round());
          if (m_n == 15) begin
            m_active = 1'b0; m_done = 1'b1; m_idx_known = 1'b0;
          end else begin
            m_n++;
          end
        end
      end else if (start) begin
        m_active = 1'b1; m_n = 0; m_dec = decrypt; m_key = key_in;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", subkey_valid, 0);  chk("rst_valid0", subkey_valid0, 0);
      chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
      chk("rst_idx", round_idx, 0);       chk("rst_subkey", subkey, 0);
      chk("rst_subkey0", subkey0, 0);
    end else begin
      chk("valid", subkey_valid, m_active);  chk("valid0", subkey_valid0, m_active);
      chk("busy", busy, m_active);           chk("busy0", busy0, m_active);
      chk("done", done, m_done);             chk("done0", done0, m_done);
      if (m_active) begin
        chk("round_idx", round_idx, m_round());
        chk("round_idx0", round_idx0, m_round());
        chk("subkey", subkey, model_key(m_key, 1'b1, m_round()));
        chk("subkey0", subkey0, model_key(m_key, 1'b0, m_round()));
      end else begin
        chk("idle_subkey", subkey, m_last1);
        chk("idle_subkey0", subkey0, m_last0);
        if (m_idx_known) chk("idle_idx", round_idx, 0);
      end
    end
  end

  task automatic start_run(input logic [63:0] k, input bit dec);
    @(negedge clk);
    key_in = k; decrypt = dec; start = 1'b1;
    hs_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      if (rnd) subkey_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("done_within_budget", done, 1);
    subkey_ready = 1'b1;
  endtask

  task automatic chk_seq_enc(input string name, input logic [63:0] k);
    chk({name, "_count"}, hs_q.size(), 16);
    for (int i = 0; i < 16 && i < hs_q.size(); i++) chk(name, hs_q[i], model_key(k, 1'b1, i));
  endtask

  initial begin
    int done_at, done_cnt, n;
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key_in = 64'd0;

    // Model pinned against FIPS worked example.
    chk("model_c0d0", model_cd0(KEY_A, 1'b1), 56'hF0CCAAF556678F);
    chk("model_k1", model_key(KEY_A, 1'b1, 0), 48'h1B02EFFC7072);
    chk("model_k2", model_key(KEY_A, 1'b1, 1), 48'h79AED9DBC9E5);
    chk("model_k16", model_key(KEY_A, 1'b1, 15), 48'hCB3D8B0E17F5);

    repeat (2) @(negedge clk);
    chk("reset_subkey_lit", subkey, 48'd0);
    chk("reset_valid_lit", subkey_valid, 0);
    #2 rst = 1'b0;

    // Encrypt, zero-wait consumer.
    @(negedge clk);
    key_in = KEY_A; decrypt = 1'b0; start = 1'b1; hs_q.delete();
    done_at = 0; done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin chk("enc_k1", subkey, 48'h1B02EFFC7072); chk("enc_k1_idx", round_idx, 0); end
      if (c == 2) chk("enc_k2", subkey, 48'h79AED9DBC9E5);
      if (c == 16) begin chk("enc_k16", subkey, 48'hCB3D8B0E17F5); chk("enc_k16_idx", round_idx, 15); end
      if (done) begin done_cnt++; done_at = c; end
    end
    chk("done_latency", done_at, 17);
    chk("done_pulses", done_cnt, 1);
    chk_seq_enc("enc_seq", KEY_A);
    for (int i = 0; i < 16; i++) enc_seq[i] = (i < hs_q.size()) ? hs_q[i] : 48'd0;

    // Decrypt, same key: reverse order.
    start_run(KEY_A, 1'b1);
    chk("dec_first", subkey, 48'hCB3D8B0E17F5);
    chk("dec_first_idx", round_idx, 15);
    repeat (15) @(negedge clk);
    chk("dec_last", subkey, 48'h1B02EFFC7072);
    chk("dec_last_idx", round_idx, 0);
    wait_done(5, 1'b0);
    chk("dec_count", hs_q.size(), 16);
    for (int i = 0; i < 16 && i < hs_q.size(); i++) chk("dec_reverse", hs_q[i], enc_seq[15-i]);

    // Backpressure: hold K3 for five cycles.
    start_run(KEY_A, 1'b0);
    repeat (2) @(negedge clk);
    subkey_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("stall_k3", subkey, model_key(KEY_A, 1'b1, 2));
      chk("stall_idx", round_idx, 2);
    end
    subkey_ready = 1'b1;
    wait_done(30, 1'b0);
    chk_seq_enc("stall_seq", KEY_A);

    // Random ready pattern.
    start_run(KEY_B, 1'b0);
    wait_done(300, 1'b1);
    chk_seq_enc("rand_seq", KEY_B);

    // Start with another key mid-schedule is ignored.
    start_run(KEY_A, 1'b0);
    repeat (3) @(negedge clk);
    key_in = KEY_B; decrypt = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(30, 1'b0);
    chk_seq_enc("midstart_seq", KEY_A);

    // Reset at step 7, then a clean full run.
    start_run(KEY_A, 1'b0);
    n = 0;
    while (m_n != 7 && n < 40) begin @(negedge clk); n++; end
    chk("reached_step7", m_n, 7);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst7_valid", subkey_valid, 0); chk("rst7_busy", busy, 0); chk("rst7_done", done, 0);
    chk("rst7_idx", round_idx, 0);      chk("rst7_subkey", subkey, 48'd0);
    #2 rst = 1'b0;
    start_run(KEY_A, 1'b0);
    wait_done(30, 1'b0);
    chk_seq_enc("post_rst_seq", KEY_A);

    // Raw C0D0 load, then back-to-back start on the done cycle.
    start_run(KEY_RAW, 1'b0);
    chk("raw_k1", subkey0, 48'h1B02EFFC7072);
    wait_done(30, 1'b0);
    chk("raw_done0", done0, 1);
    key_in = KEY_RAW; decrypt = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_valid0", subkey_valid0, 1);
    chk("b2b_idx0", round_idx0, 15);
    chk("b2b_k16", subkey0, 48'hCB3D8B0E17F5);
    wait_done(30, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
